// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle ops plus a shift-add multiply, with a
// Start/Ready/Done handshake and registered result and flags.
module alu_seq #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Selection,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             V
);
    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE_MUL} state_t;

    state_t             state_q;
    logic               ready_q, done_q;
    logic [WIDTH-1:0]   s_q;
    logic               c_q, z_q, n_q, v_q;
    logic [WIDTH-1:0]   al_q, bl_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q;

    logic [WIDTH-1:0]   op_s;
    logic               op_c, op_v;
    logic [WIDTH:0]     ext;
    logic [SHW-1:0]     sh;

    // Single-cycle ops are evaluated straight from the inputs so the result
    // is registered on the accept edge and Done shows in the next cycle.
    always_comb begin
        op_s = '0;
        op_c = 1'b0;
        op_v = 1'b0;
        ext  = '0;
        sh   = B[SHW-1:0];
        case (Selection)
            4'h0: begin
                ext  = {1'b0, A} + {1'b0, B};
                op_s = ext[M:0];
                op_c = ext[WIDTH];
                op_v = (A[M] == B[M]) && (op_s[M] != A[M]);
            end
            4'h1: begin
                ext  = {1'b0, A} - {1'b0, B};
                op_s = ext[M:0];
                op_c = ext[WIDTH];
                op_v = (A[M] != B[M]) && (op_s[M] != A[M]);
            end
            4'h2: begin
                ext  = {1'b0, A} + (WIDTH+1)'(1);
                op_s = ext[M:0];
                op_c = ext[WIDTH];
                op_v = !A[M] && op_s[M];
            end
            4'h3: op_s = A;
            4'h4: op_s = A & B;
            4'h5: op_s = A | B;
            4'h6: op_s = A ^ B;
            // Shifts run one bit wider so the last bit shifted out lands in ext.
            4'h8: begin
                ext  = {1'b0, A} << sh;
                op_s = ext[M:0];
                op_c = ext[WIDTH];
            end
            4'h9: begin
                ext  = {A, 1'b0} >> sh;
                op_s = ext[WIDTH:1];
                op_c = ext[0];
            end
            4'hA: begin
                ext  = $signed({A, 1'b0}) >>> sh;
                op_s = ext[WIDTH:1];
                op_c = ext[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (bl_q[cnt_q])
            acc_d = acc_q + ({{WIDTH{1'b0}}, al_q} << cnt_q);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            al_q    <= '0;
            bl_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        al_q    <= A;
                        bl_q    <= B;
                        ready_q <= 1'b0;
                        if (Selection == 4'hB) begin
                            state_q <= MUL;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                        end else begin
                            state_q <= EXEC;
                            s_q     <= op_s;
                            c_q     <= op_c;
                            v_q     <= op_v;
                            z_q     <= (op_s == '0);
                            n_q     <= op_s[M];
                            done_q  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Last partial product: publish the result on this edge.
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        state_q <= DONE_MUL;
                        s_q     <= acc_d[M:0];
                        c_q     <= |acc_d[2*WIDTH-1:WIDTH];
                        v_q     <= 1'b0;
                        z_q     <= (acc_d[M:0] == '0);
                        n_q     <= acc_d[M];
                        done_q  <= 1'b1;
                    end
                end
                EXEC, DONE_MUL: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ready = ready_q;
    assign Done  = done_q;
    assign S     = s_q;
    assign C     = c_q;
    assign Z     = z_q;
    assign N     = n_q;
    assign V     = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: cycle-level reference model plus literal checks.
module tb_alu_seq;
    localparam int W       = 16;
    localparam int MUL_LAT = W + 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [3:0]    Selection = 4'h0;
    logic [W-1:0]  A = '0, B = '0;
    logic          Ready, Done, C, Z, N, V;
    logic [W-1:0]  S;

    alu_seq #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Selection(Selection),
        .A(A), .B(B), .Ready(Ready), .Done(Done), .S(S),
        .C(C), .Z(Z), .N(N), .V(V)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers, straight from the function table.
    function automatic void model_op(input logic [3:0] sel, input longint a, input longint b,
                                     output longint s, output bit c, output bit v);
        longint mask = (longint'(1) << W) - 1;
        longint half = longint'(1) << (W - 1);
        longint sa   = (a >= half) ? a - (mask + 1) : a;
        longint sb   = (b >= half) ? b - (mask + 1) : b;
        longint sh   = b % W;
        longint r;
        s = 0; c = 0; v = 0;
        case (sel)
            4'h0: begin r = a + b; s = r & mask; c = r > mask; v = (sa + sb >= half) || (sa + sb < -half); end
            4'h1: begin s = (a - b) & mask; c = a < b; v = (sa - sb >= half) || (sa - sb < -half); end
            4'h2: begin r = a + 1; s = r & mask; c = r > mask; v = (sa + 1 >= half); end
            4'h3: s = a;
            4'h4: s = a & b;
            4'h5: s = a | b;
            4'h6: s = a ^ b;
            4'h8: begin s = (a << sh) & mask; c = (sh > 0) && (((a >> (W - sh)) & 1) == 1); end
            4'h9: begin s = a >> sh; c = (sh > 0) && (((a >> (sh - 1)) & 1) == 1); end
            4'hA: begin s = (sa >>> sh) & mask; c = (sh > 0) && (((a >> (sh - 1)) & 1) == 1); end
            4'hB: begin r = a * b; s = r & mask; c = (r >> W) != 0; end
            default: ;
        endcase
    endfunction

    // Model state: cycles left in the current operation; Done is the last one.
    int           m_rem = 0;
    longint       p_s;
    bit           p_c, p_v;
    logic [W-1:0] m_s = '0;
    logic         m_c = 0, m_z = 0, m_n = 0, m_v = 0;
    bit           chk_en = 0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_rem = 0; m_s = '0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        end else begin
            if (m_rem == 0) begin
                if (Start) begin
                    model_op(Selection, longint'(A), longint'(B), p_s, p_c, p_v);
                    m_rem = (Selection == 4'hB) ? MUL_LAT : 1;
                end
            end else
                m_rem--;
            if (m_rem == 1) begin
                m_s = p_s[W-1:0]; m_c = p_c; m_v = p_v;
                m_z = (p_s == 0); m_n = p_s[W-1];
            end
        end
        chk_en = 1;
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            check("Ready", Ready, m_rem == 0);
            check("Done",  Done,  m_rem == 1);
            check("S", S, m_s);
            check("C", C, m_c);
            check("Z", Z, m_z);
            check("N", N, m_n);
            check("V", V, m_v);
        end
    end

    task automatic issue(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge Clock); #2;
        Start = 1; Selection = sel; A = a; B = b;
        @(posedge Clock); #2;
        Start = 0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(negedge Clock);
            cyc++;
        end while (!Done && cyc < maxc);
        if (!Done) begin
            n_vec++; n_bad++;
            $display("FAIL timeout: no Done within %0d cycles", maxc);
        end
    endtask

    task automatic run_op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name);
        int cyc;
        issue(sel, a, b);
        wait_done(4, cyc);
        check({name, " latency"}, cyc, 1);
    endtask

    logic [35:0] vecs [10] = '{
        {4'h3, 16'hF0F0, 16'hFF00}, {4'h4, 16'hF0F0, 16'hFF00},
        {4'h5, 16'hF0F0, 16'hFF00}, {4'h6, 16'hF0F0, 16'hFF00},
        {4'h7, 16'hF0F0, 16'hFF00}, {4'h0, 16'hFFFF, 16'h0002},
        {4'h1, 16'h8000, 16'h0001}, {4'hA, 16'h8000, 16'h000F},
        {4'h9, 16'hC000, 16'h000F}, {4'hF, 16'h0000, 16'h0000}
    };

    initial begin
        int cyc, ndone;
        logic [35:0] vv;
        repeat (2) @(posedge Clock);
        #2 Reset = 0;
        @(negedge Clock);
        check("reset Ready", Ready, 1);
        check("reset S", S, 0);

        run_op(4'h0, 16'h7FFF, 16'h0001, "ADD");
        check("ADD S", S, 16'h8000);
        check("ADD CZNV", {C, Z, N, V}, 4'b0011);

        run_op(4'h1, 16'h0003, 16'h0004, "SUB");
        check("SUB S", S, 16'hFFFF);
        check("SUB CNV", {C, N, V}, 3'b110);

        run_op(4'h2, 16'hFFFF, 16'h0000, "INC");
        check("INC S", S, 16'h0000);
        check("INC CZ", {C, Z}, 2'b11);

        run_op(4'h8, 16'h8001, 16'h0001, "SHL");
        check("SHL S", S, 16'h0002);
        check("SHL C", C, 1);
        run_op(4'h9, 16'h8001, 16'h0001, "SHR");
        check("SHR S", S, 16'h4000);
        check("SHR C", C, 1);
        run_op(4'hA, 16'h8001, 16'h0001, "ASR");
        check("ASR S", S, 16'hC000);
        check("ASR C", C, 1);
        run_op(4'h8, 16'h8001, 16'h0000, "SHL0");
        check("SHL0 S", S, 16'h8001);
        check("SHL0 C", C, 0);

        for (int i = 0; i < 10; i++) begin
            vv = vecs[i];
            run_op(vv[35:32], vv[31:16], vv[15:0], "table");
        end

        // Multiply with stray Start pulses while busy.
        issue(4'hB, 16'h0100, 16'h0101);
        cyc = 0;
        do begin
            @(negedge Clock);
            cyc++;
            if (cyc == 3) Start = 1;
            if (cyc == 6) Start = 0;
        end while (!Done && cyc < 40);
        check("MUL latency", cyc, 17);
        check("MUL S", S, 16'h0100);
        check("MUL C", C, 1);

        // Reset in the middle of a multiply.
        issue(4'hB, 16'h1234, 16'h5678);
        repeat (4) @(negedge Clock);
        Reset = 1;
        @(posedge Clock); #2 Reset = 0;
        @(negedge Clock);
        check("midrst Ready", Ready, 1);
        check("midrst Done", Done, 0);
        check("midrst S", S, 0);
        check("midrst CZNV", {C, Z, N, V}, 4'b0000);
        run_op(4'h0, 16'h0003, 16'h0004, "ADD37");
        check("ADD37 S", S, 16'h0007);

        run_op(4'hE, 16'h1234, 16'h0000, "RSV");
        check("RSV S", S, 0);
        check("RSV CZV", {C, Z, V}, 3'b010);

        // Start held high: one accept every other cycle.
        @(posedge Clock); #2;
        Start = 1; Selection = 4'h2; A = 16'h0010; B = '0;
        ndone = 0;
        repeat (8) begin
            @(negedge Clock);
            if (Done) ndone++;
        end
        Start = 0;
        check("b2b Done count", ndone, 4);

        repeat (3) @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
